// File: rtl/tim_reg_pkg.sv
// Shared timer register map.
//   TIER_ADDR / TISR_ADDR : register offsets on the timer register bus
//   INT_ST_BIT, OVF_BIT, EVT_CNT_LSB : TISR field positions
package tim_reg_pkg;

  localparam logic [11:0] TIER_ADDR = 12'h14;
  localparam logic [11:0] TISR_ADDR = 12'h18;

  localparam int unsigned INT_ST_BIT  = 0;
  localparam int unsigned OVF_BIT     = 1;
  localparam int unsigned EVT_CNT_LSB = 8;

endpackage

// File: rtl/rise_det.sv
// One-flop rising-edge detector.
//   clk  : clock
//   rst  : synchronous active-high reset, loads the delay flop with RST_VAL
//   d    : level input, synchronous to clk
//   rise : d & ~d_q (combinational)
module rise_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= RST_VAL;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/tisr_int_gen.sv
// Timer interrupt status (TISR) and interrupt generation.
// Records rising edges of cnt_match as a sticky W1C status flag, an
// overflow flag and a saturating event counter; drives the registered
// interrupt line gated by the TIER enable bit.
//   clk, rst  : clock, synchronous active-high reset
//   wr_data   : register write data (bit0 clears int_st, bit1 clears ovf)
//   addr      : register address
//   wr_en     : register write strobe
//   int_en    : TIER enable bit
//   cnt_match : compare-match level from timer core
//   rd_data   : TISR contents
//   tim_int   : interrupt request, registered
module tisr_int_gen
  import tim_reg_pkg::*;
#(
  parameter logic [11:0] TISR_ADDR = tim_reg_pkg::TISR_ADDR,
  parameter int unsigned CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wr_data,
  input  logic [11:0] addr,
  input  logic        wr_en,
  input  logic        int_en,
  input  logic        cnt_match,
  output logic [31:0] rd_data,
  output logic        tim_int
);

  localparam logic [CNT_W-1:0] EVT_MAX = '1;

  logic             rise;
  logic             wsel;
  logic             clr0;
  logic             clr1;
  logic             int_st;
  logic             ovf;
  logic [CNT_W-1:0] evt_cnt;
  logic             unused_wr_data;

  // Delay flop resets to 1 so a match held high across reset release
  // is not counted as an event.
  rise_det #(
    .RST_VAL (1'b1)
  ) u_rise_det (
    .clk  (clk),
    .rst  (rst),
    .d    (cnt_match),
    .rise (rise)
  );

  assign wsel = wr_en & (addr == TISR_ADDR);
  assign clr0 = wsel & wr_data[INT_ST_BIT];
  assign clr1 = wsel & wr_data[OVF_BIT];

  assign unused_wr_data = ^wr_data[31:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      int_st  <= 1'b0;
      ovf     <= 1'b0;
      evt_cnt <= '0;
      tim_int <= 1'b0;
    end else begin
      // A new event wins over a simultaneous clear.
      if (rise)      int_st <= 1'b1;
      else if (clr0) int_st <= 1'b0;

      if (rise && int_st) ovf <= 1'b1;
      else if (clr1)      ovf <= 1'b0;

      // Clearing int_st also restarts the count; a same-cycle event is
      // counted as the first one of the new window.
      if (clr0)                           evt_cnt <= rise ? CNT_W'(1) : '0;
      else if (rise && evt_cnt != EVT_MAX) evt_cnt <= evt_cnt + 1'b1;

      tim_int <= int_st & int_en;
    end
  end

  always_comb begin
    rd_data                          = '0;
    rd_data[INT_ST_BIT]              = int_st;
    rd_data[OVF_BIT]                 = ovf;
    rd_data[EVT_CNT_LSB +: CNT_W]    = evt_cnt;
  end

endmodule

// File: tb/tb_tisr_int_gen.sv
module tb_tisr_int_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wr_data;
  logic [11:0] addr;
  logic        wr_en;
  logic        int_en;
  logic        cnt_match;
  logic [31:0] rd_data;
  logic        tim_int;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  tisr_int_gen #(
    .TISR_ADDR (12'h18),
    .CNT_W     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_data   (wr_data),
    .addr      (addr),
    .wr_en     (wr_en),
    .int_en    (int_en),
    .cnt_match (cnt_match),
    .rd_data   (rd_data),
    .tim_int   (tim_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    cnt_match = 1'b0;
    tick();
    cnt_match = 1'b1;
    tick();
  endtask

  task automatic reg_wr(input logic [11:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    addr    = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    wr_data = '0;
    addr    = '0;
  endtask

  initial begin
    rst = 1'b1; wr_data = '0; addr = '0; wr_en = 1'b0;
    int_en = 1'b0; cnt_match = 1'b1;
    tick();
    tick();
    check("reset_rd", rd_data, 32'h0);
    check("reset_int", {31'b0, tim_int}, 32'h0);
    rst = 1'b0;

    // Match held high across reset release: no event.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_rd", rd_data, 32'h0);
      check("hold_int", {31'b0, tim_int}, 32'h0);
    end

    int_en = 1'b1;
    pulse();
    check("first_evt_rd", rd_data, 32'h0000_0101);
    check("first_evt_int_lag", {31'b0, tim_int}, 32'h0);
    tick();
    check("first_evt_int", {31'b0, tim_int}, 32'h1);
    check("level_one_evt", rd_data, 32'h0000_0101);

    reg_wr(12'h18, 32'h3);
    check("clr_a_rd", rd_data, 32'h0);
    check("clr_a_int_lag", {31'b0, tim_int}, 32'h1);
    tick();
    check("clr_a_int", {31'b0, tim_int}, 32'h0);

    // Three separated events without clearing.
    pulse(); pulse(); pulse();
    check("three_evt_rd", rd_data, 32'h0000_0303);
    reg_wr(12'h18, 32'h3);
    check("clr_b_rd", rd_data, 32'h0);
    tick();
    check("clr_b_int", {31'b0, tim_int}, 32'h0);

    // Clear of bit0 coincident with a rise.
    cnt_match = 1'b0;
    tick();
    cnt_match = 1'b1;
    reg_wr(12'h18, 32'h1);
    check("clr_vs_rise", rd_data, 32'h0000_0101);
    reg_wr(12'h18, 32'h0);
    check("w1c_zero", rd_data, 32'h0000_0101);

    // ovf only clear via bit1; bit0 clear alone leaves it.
    pulse();
    check("ovf_set", rd_data, 32'h0000_0203 | 32'h0000_0001);
    reg_wr(12'h18, 32'h1);
    check("clr0_only", rd_data, 32'h0000_0002);
    reg_wr(12'h18, 32'h2);
    check("clr1_only", rd_data, 32'h0);

    // Saturation.
    for (int i = 1; i <= 300; i++) begin
      pulse();
      if (i == 254) check("cnt_254", rd_data, 32'h0000_FE03);
      if (i == 255) check("cnt_255", rd_data, 32'h0000_FF03);
    end
    check("cnt_sat", rd_data, 32'h0000_FF03);

    // Enable gating with one-cycle lag.
    tick();
    check("en_on_int", {31'b0, tim_int}, 32'h1);
    int_en = 1'b0;
    check("en_fall_lag", {31'b0, tim_int}, 32'h1);
    tick();
    check("en_fall", {31'b0, tim_int}, 32'h0);
    int_en = 1'b1;
    check("en_rise_lag", {31'b0, tim_int}, 32'h0);
    tick();
    check("en_rise", {31'b0, tim_int}, 32'h1);
    int_en = 1'b0;
    tick();
    check("en_fall2", {31'b0, tim_int}, 32'h0);

    // Writes to other addresses are ignored.
    reg_wr(12'h14, 32'hFFFF_FFFF);
    check("wr_tier", rd_data, 32'h0000_FF03);
    reg_wr(12'h1C, 32'hFFFF_FFFF);
    check("wr_1c", rd_data, 32'h0000_FF03);

    // Reset mid-count.
    int_en = 1'b1;
    reg_wr(12'h18, 32'h3);
    check("clr_c_rd", rd_data, 32'h0);
    for (int i = 0; i < 5; i++) pulse();
    check("five_evt", rd_data, 32'h0000_0503);
    tick();
    check("pre_rst_int", {31'b0, tim_int}, 32'h1);
    cnt_match = 1'b0;
    tick();
    rst = 1'b1;
    cnt_match = 1'b1;
    wr_en = 1'b1; addr = 12'h18; wr_data = 32'h0;
    tick();
    rst = 1'b0;
    wr_en = 1'b0; addr = '0;
    check("mid_rst_rd", rd_data, 32'h0);
    check("mid_rst_int", {31'b0, tim_int}, 32'h0);
    tick();
    check("post_rst_rd", rd_data, 32'h0);
    check("post_rst_int", {31'b0, tim_int}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
